// File: rtl/udp_code_extract.sv
// Extracts a 256-bit verification code from a framed UDP payload
// (55 AA 5A 20 <32 code bytes> <xor checksum>) and flags malformed code frames.
module udp_code_extract (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [7:0]   i_udp_data,
    input  logic         i_udp_valid,
    input  logic         i_udp_last,
    output logic [255:0] o_code_data,
    output logic         o_code_vld,
    output logic         o_frame_err,
    output logic [7:0]   o_err_cnt
);

    localparam logic [7:0] SYNC0_BYTE = 8'h55;
    localparam logic [7:0] SYNC1_BYTE = 8'hAA;
    localparam logic [7:0] CMD_BYTE   = 8'h5A;
    localparam logic [7:0] LEN_BYTE   = 8'h20;
    localparam logic [4:0] LAST_IDX   = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR1    = 3'd1,
        ST_CMD     = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CHK     = 3'd5,
        ST_DROP    = 3'd6
    } state_t;

    // Running checksum step; the frame checksum covers cmd, len and every code byte.
    function automatic logic [7:0] chk_accum(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t         state_r;
    state_t         state_s;
    logic [4:0]     cnt_r;
    logic [7:0]     xor_r;
    logic [255:0]   shift_r;
    logic           start_s;
    logic           shift_s;
    logic           load_s;
    logic           err_s;

    // Next-state and per-byte action decode; only a valid byte moves the parser.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        shift_s = 1'b0;
        load_s  = 1'b0;
        err_s   = 1'b0;
        if (i_udp_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (i_udp_last) begin
                        state_s = ST_IDLE;
                    end else if (i_udp_data == SYNC0_BYTE) begin
                        state_s = ST_HDR1;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                ST_HDR1: begin
                    if (i_udp_last) begin
                        state_s = ST_IDLE;
                    end else if (i_udp_data == SYNC1_BYTE) begin
                        state_s = ST_CMD;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                ST_CMD: begin
                    // Foreign commands are silently skipped, not counted as errors.
                    if (i_udp_last) begin
                        state_s = ST_IDLE;
                    end else if (i_udp_data == CMD_BYTE) begin
                        state_s = ST_LEN;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                ST_LEN: begin
                    if (i_udp_last) begin
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else if (i_udp_data == LEN_BYTE) begin
                        start_s = 1'b1;
                        state_s = ST_PAYLOAD;
                    end else begin
                        err_s   = 1'b1;
                        state_s = ST_DROP;
                    end
                end
                ST_PAYLOAD: begin
                    shift_s = 1'b1;
                    if (i_udp_last) begin
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else if (cnt_r == LAST_IDX) begin
                        state_s = ST_CHK;
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end
                ST_CHK: begin
                    if (i_udp_data != xor_r) begin
                        err_s   = 1'b1;
                        state_s = i_udp_last ? ST_IDLE : ST_DROP;
                    end else if (i_udp_last) begin
                        load_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        err_s   = 1'b1;
                        state_s = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (i_udp_last) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Parser state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Code byte counter, running checksum and code shift register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r   <= 5'd0;
            xor_r   <= 8'd0;
            shift_r <= 256'd0;
        end else if (start_s) begin
            cnt_r   <= 5'd0;
            xor_r   <= chk_accum(CMD_BYTE, i_udp_data);
            shift_r <= 256'd0;
        end else if (shift_s) begin
            cnt_r   <= cnt_r + 5'd1;
            xor_r   <= chk_accum(xor_r, i_udp_data);
            shift_r <= {shift_r[247:0], i_udp_data};
        end else begin
            cnt_r   <= cnt_r;
            xor_r   <= xor_r;
            shift_r <= shift_r;
        end
    end

    // Registered result: code is only replaced by a fully validated frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_code_data <= 256'd0;
            o_code_vld  <= 1'b0;
        end else begin
            o_code_vld <= load_s;
            if (load_s) begin
                o_code_data <= shift_r;
            end else begin
                o_code_data <= o_code_data;
            end
        end
    end

    // Error pulse and saturating error counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_err <= 1'b0;
            o_err_cnt   <= 8'd0;
        end else begin
            o_frame_err <= err_s;
            if (err_s && (o_err_cnt != 8'hFF)) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end else begin
                o_err_cnt <= o_err_cnt;
            end
        end
    end

endmodule

// File: tb/tb_udp_code_extract.sv
// Directed bench for udp_code_extract: a frame-level model predicts the outcome of
// each whole frame and a per-cycle compare process checks every DUT output.
module tb_udp_code_extract;

    logic         i_clk;
    logic         i_rst;
    logic [7:0]   i_udp_data;
    logic         i_udp_valid;
    logic         i_udp_last;
    logic [255:0] o_code_data;
    logic         o_code_vld;
    logic         o_frame_err;
    logic [7:0]   o_err_cnt;

    udp_code_extract dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_udp_data  (i_udp_data),
        .i_udp_valid (i_udp_valid),
        .i_udp_last  (i_udp_last),
        .o_code_data (o_code_data),
        .o_code_vld  (o_code_vld),
        .o_frame_err (o_frame_err),
        .o_err_cnt   (o_err_cnt)
    );

    localparam logic [255:0] CODE_1_32 =
        256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;

    int n_total  = 0;
    int n_passed = 0;
    int vld_seen = 0;

    logic [7:0]   frm[$];
    bit           pend_vld;
    bit           pend_err;
    logic [255:0] pend_code;
    bit           exp_vld;
    bit           exp_err;
    logic [7:0]   exp_cnt;
    logic [255:0] exp_code;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_total++;
        if (act !== req) begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end else begin
            n_passed++;
        end
    endtask

    // Frame-level judgement: where (if anywhere) the frame goes wrong and what it delivers.
    function automatic void analyze(output int eidx, output bit good, output logic [255:0] code);
        int n;
        logic [7:0] x;
        n    = frm.size();
        eidx = -1;
        good = 1'b0;
        code = 256'd0;
        if (n < 4 || frm[0] != 8'h55 || frm[1] != 8'hAA || frm[2] != 8'h5A) return;
        if (n == 4 || frm[3] != 8'h20) begin
            eidx = 3;
            return;
        end
        if (n <= 36) begin
            eidx = n - 1;
            return;
        end
        x = frm[2] ^ frm[3];
        for (int i = 4; i < 36; i++) begin
            x    = x ^ frm[i];
            code = {code[247:0], frm[i]};
        end
        if (frm[36] != x || n > 37) begin
            eidx = 36;
            return;
        end
        good = 1'b1;
    endfunction

    // Expected outputs one clock after the byte that causes them.
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            exp_vld  <= 1'b0;
            exp_err  <= 1'b0;
            exp_cnt  <= 8'd0;
            exp_code <= 256'd0;
        end else begin
            exp_vld <= pend_vld;
            exp_err <= pend_err;
            if (pend_err && exp_cnt != 8'hFF) exp_cnt <= exp_cnt + 8'd1;
            if (pend_vld) exp_code <= pend_code;
        end
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            check("code_vld",  {255'd0, o_code_vld},  {255'd0, exp_vld});
            check("frame_err", {255'd0, o_frame_err}, {255'd0, exp_err});
            check("err_cnt",   {248'd0, o_err_cnt},   {248'd0, exp_cnt});
            check("code_data", o_code_data, exp_code);
            if (o_code_vld === 1'b1) vld_seen++;
        end
    end

    task automatic drive_byte(input logic [7:0] b, input bit lst, input bit e, input bit v,
                              input logic [255:0] c);
        i_udp_data  = b;
        i_udp_valid = 1'b1;
        i_udp_last  = lst;
        pend_err    = e;
        pend_vld    = v;
        pend_code   = c;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_cycle();
        i_udp_valid = 1'b0;
        i_udp_last  = 1'b0;
        i_udp_data  = 8'h00;
        pend_err    = 1'b0;
        pend_vld    = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst       = 1'b1;
        i_udp_valid = 1'b0;
        i_udp_last  = 1'b0;
        pend_err    = 1'b0;
        pend_vld    = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic run_frame(input bit gaps, input int rst_at);
        int eidx;
        bit good;
        logic [255:0] code;
        int n;
        analyze(eidx, good, code);
        n = frm.size();
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                do_reset();
                return;
            end
            if (gaps) begin
                for (int k = 0; k < 3; k++) begin
                    if ($urandom_range(0, 2) == 0) idle_cycle();
                end
            end
            drive_byte(frm[i], i == n - 1, i == eidx, good && (i == n - 1), code);
        end
    endtask

    task automatic build_good(input int pat);
        logic [7:0] x;
        logic [7:0] b;
        frm.delete();
        frm.push_back(8'h55);
        frm.push_back(8'hAA);
        frm.push_back(8'h5A);
        frm.push_back(8'h20);
        x = 8'h5A ^ 8'h20;
        for (int i = 0; i < 32; i++) begin
            b = (pat == 0) ? 8'(i + 1) : (8'hA0 ^ 8'(i * 7));
            x = x ^ b;
            frm.push_back(b);
        end
        frm.push_back((pat == 0) ? 8'h5A : x);
    endtask

    initial begin
        i_rst       = 1'b1;
        i_udp_valid = 1'b0;
        i_udp_last  = 1'b0;
        i_udp_data  = 8'h00;
        pend_vld    = 1'b0;
        pend_err    = 1'b0;
        pend_code   = 256'd0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("rst_code", o_code_data, 256'd0);
        check("rst_cnt",  {248'd0, o_err_cnt}, 256'd0);
        check("rst_vld",  {255'd0, o_code_vld}, 256'd0);

        build_good(0);
        run_frame(1'b0, -1);
        idle_cycle();
        check("good_code", o_code_data, CODE_1_32);
        check("good_cnt",  {248'd0, o_err_cnt}, 256'd0);
        check("good_vlds", 256'(vld_seen), 256'd1);

        run_frame(1'b1, -1);
        idle_cycle();
        check("gap_code", o_code_data, CODE_1_32);
        check("gap_vlds", 256'(vld_seen), 256'd2);

        build_good(0);
        frm[36] = frm[36] ^ 8'h01;
        run_frame(1'b0, -1);
        idle_cycle();
        check("cs_cnt",  {248'd0, o_err_cnt}, 256'd1);
        check("cs_code", o_code_data, CODE_1_32);
        check("cs_vlds", 256'(vld_seen), 256'd2);

        build_good(0);
        frm[2] = 8'h33;
        run_frame(1'b0, -1);
        build_good(0);
        run_frame(1'b0, -1);
        idle_cycle();
        check("cmd_cnt",  {248'd0, o_err_cnt}, 256'd1);
        check("cmd_vlds", 256'(vld_seen), 256'd3);

        build_good(1);
        run_frame(1'b1, -1);
        idle_cycle();
        check("pat1_vlds", 256'(vld_seen), 256'd4);

        build_good(0);
        frm.push_back(8'h00);
        run_frame(1'b0, -1);
        build_good(0);
        frm[3] = 8'h10;
        run_frame(1'b0, -1);
        frm.delete();
        frm.push_back(8'h12);
        frm.push_back(8'h34);
        run_frame(1'b0, -1);
        idle_cycle();
        check("misc_cnt", {248'd0, o_err_cnt}, 256'd3);

        build_good(0);
        run_frame(1'b0, 10);
        check("mid_rst_code", o_code_data, 256'd0);
        build_good(0);
        run_frame(1'b1, -1);
        idle_cycle();
        check("rst_vlds", 256'(vld_seen), 256'd5);
        check("rst_ecnt", {248'd0, o_err_cnt}, 256'd0);
        check("rst_good_code", o_code_data, CODE_1_32);

        build_good(0);
        while (frm.size() > 21) void'(frm.pop_back());
        for (int r = 0; r < 256; r++) run_frame(1'b0, -1);
        idle_cycle();
        idle_cycle();
        check("sat_cnt",  {248'd0, o_err_cnt}, 256'hFF);
        check("sat_code", o_code_data, CODE_1_32);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
